// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: funct3 encodings, FSM states
// and a small decode helper.
package exec_pkg;

  // ALU class (op = 0) funct3 encodings
  localparam logic [2:0] ADD  = 3'd0;
  localparam logic [2:0] SUB  = 3'd1;
  localparam logic [2:0] XOR  = 3'd2;
  localparam logic [2:0] AND  = 3'd3;
  localparam logic [2:0] OR   = 3'd4;
  localparam logic [2:0] SLL  = 3'd5;
  localparam logic [2:0] SRL  = 3'd6;
  localparam logic [2:0] ROTL = 3'd7;

  // Multiply class (op = 1) funct3 encodings
  localparam logic [2:0] MUL  = 3'd0;
  localparam logic [2:0] MULH = 3'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } exec_state_e;

  // True for the two legal multiply-class encodings.
  function automatic logic is_mul_f3(input logic [2:0] f3);
    return (f3 == MUL) || (f3 == MULH);
  endfunction

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative unsigned shift-add multiplier, LSB-first over operand b.
// Radix-2 by default; defining EXEC_RADIX4_EN retires two bits of b per
// cycle. The full 2D-bit product stays on 'product' after the last step.
module exec_mul_seq #(
  parameter int D = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clear,
  input  logic           start,
  input  logic [D-1:0]   a,
  input  logic [D-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*D-1:0] product
);

  localparam int CW = $clog2(D);
`ifdef EXEC_RADIX4_EN
  localparam int BPS = 2;
`else
  localparam int BPS = 1;
`endif
  localparam logic [CW-1:0] CNT_LAST = CW'(D / BPS - 1);

  logic [D-1:0]   a_r;
  logic [D-1:0]   b_r;
  logic [2*D-1:0] prod_r;
  logic [CW-1:0]  cnt_r;
  logic           busy_r;

  logic [2*D-1:0] prod_step_s;
  logic [D-1:0]   b_step_s;

`ifdef EXEC_RADIX4_EN
  logic [D+1:0] pp_s;
  logic [D+1:0] sum_s;

  // Radix-4 step: add 0/A/2A/3A to the upper half, shift right by two.
  always_comb begin
    case (b_r[1:0])
      2'd0:    pp_s = '0;
      2'd1:    pp_s = {2'b00, a_r};
      2'd2:    pp_s = {1'b0, a_r, 1'b0};
      2'd3:    pp_s = {2'b00, a_r} + {1'b0, a_r, 1'b0};
      default: pp_s = '0;
    endcase
    sum_s       = {2'b00, prod_r[2*D-1:D]} + pp_s;
    prod_step_s = {sum_s, prod_r[D-1:2]};
    b_step_s    = b_r >> 2;
  end
`else
  logic [D:0] sum_s;

  // Radix-2 step: conditionally add A to the upper half, shift right by one.
  always_comb begin
    if (b_r[0]) begin
      sum_s = {1'b0, prod_r[2*D-1:D]} + {1'b0, a_r};
    end else begin
      sum_s = {1'b0, prod_r[2*D-1:D]};
    end
    prod_step_s = {sum_s, prod_r[D-1:1]};
    b_step_s    = b_r >> 1;
  end
`endif

  // Operand capture, step counter and accumulator; clear aborts a run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_r    <= '0;
      b_r    <= '0;
      prod_r <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      a_r    <= a;
      b_r    <= b;
      prod_r <= '0;
      cnt_r  <= CNT_LAST;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      prod_r <= prod_step_s;
      b_r    <= b_step_s;
      if (cnt_r == '0) begin
        busy_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end
  end

  assign busy    = busy_r;
  assign done    = busy_r & (cnt_r == '0);
  assign product = prod_r;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus an iterative unsigned multiplier
// with upstream back-pressure. Optional build macro EXEC_RADIX4_EN selects
// the two-bits-per-cycle multiplier (results identical, shorter latency).
module exec_stage
  import exec_pkg::*;
#(
  parameter int P = 16,
  parameter int D = 32,
  parameter int R = 5,
  parameter int F = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         valid_i,
  input  logic [P-1:0] next_pc_i,
  input  logic         op_i,
  input  logic [F-1:0] funct3_i,
  input  logic [R-1:0] rd_i,
  input  logic [D-1:0] rs_i,
  input  logic [D-1:0] rt_i,
  output logic         stall_o,
  output logic         valid_o,
  output logic [P-1:0] next_pc_o,
  output logic [R-1:0] rd_o,
  output logic [D-1:0] result_o
);

  localparam int SHW = $clog2(D);

  exec_state_e state_r, state_nxt_s;

  logic           start_s;
  logic           mul_start_s;
  logic           mul_clear_s;
  logic           mul_busy_s;
  logic           mul_done_s;
  logic [2*D-1:0] mul_prod_s;
  logic [D-1:0]   mul_res_s;

  logic [SHW-1:0] sh_s;
  logic [SHW:0]   rsh_s;
  logic [D-1:0]   rot_s;
  logic [D-1:0]   alu_res_s;

  logic           valid_r,  valid_nxt_s;
  logic [D-1:0]   result_r, result_nxt_s;
  logic [R-1:0]   rd_r,     rd_nxt_s;
  logic [P-1:0]   pc_r,     pc_nxt_s;

  logic [F-1:0]   f3_hold_r;
  logic [R-1:0]   rd_hold_r;
  logic [P-1:0]   pc_hold_r;

  assign start_s = valid_i & op_i & is_mul_f3(funct3_i);
  assign sh_s    = rt_i[SHW-1:0];
  assign rsh_s   = (SHW+1)'(D) - {1'b0, sh_s};

  exec_mul_seq #(.D(D)) u_mul (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (mul_clear_s),
    .start   (mul_start_s),
    .a       (rs_i),
    .b       (rt_i),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign mul_res_s = (f3_hold_r == MULH) ? mul_prod_s[2*D-1:D] : mul_prod_s[D-1:0];

  // Rotate-left by sh; a zero amount passes the operand through unchanged.
  always_comb begin
    if (sh_s == '0) begin
      rot_s = rs_i;
    end else begin
      rot_s = (rs_i << sh_s) | (rs_i >> rsh_s);
    end
  end

  // Single-cycle ALU, all arithmetic modulo 2^D.
  always_comb begin
    case (funct3_i)
      ADD:     alu_res_s = rs_i + rt_i;
      SUB:     alu_res_s = rs_i - rt_i;
      XOR:     alu_res_s = rs_i ^ rt_i;
      AND:     alu_res_s = rs_i & rt_i;
      OR:      alu_res_s = rs_i | rt_i;
      SLL:     alu_res_s = rs_i << sh_s;
      SRL:     alu_res_s = rs_i >> sh_s;
      ROTL:    alu_res_s = rot_s;
      default: alu_res_s = '0;
    endcase
  end

  // Upstream must hold while a multiply is being accepted or iterating.
  assign stall_o = rst_ni & ((state_r == BUSY) |
                             ((state_r == IDLE) & start_s & ~flush_i));

  // Next-state and output-register next values; flush wins everywhere.
  always_comb begin
    state_nxt_s  = state_r;
    mul_start_s  = 1'b0;
    mul_clear_s  = 1'b0;
    valid_nxt_s  = 1'b0;
    result_nxt_s = result_r;
    rd_nxt_s     = rd_r;
    pc_nxt_s     = pc_r;
    case (state_r)
      IDLE: begin
        if (flush_i) begin
          state_nxt_s = IDLE;
        end else if (start_s) begin
          state_nxt_s = BUSY;
          mul_start_s = 1'b1;
        end else begin
          valid_nxt_s  = valid_i;
          result_nxt_s = op_i ? '0 : alu_res_s;
          rd_nxt_s     = rd_i;
          pc_nxt_s     = next_pc_i;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_nxt_s = IDLE;
          mul_clear_s = 1'b1;
        end else if (mul_done_s) begin
          state_nxt_s = DONE;
        end else if (!mul_busy_s) begin
          // multiplier lost its run: recover rather than wait forever
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (flush_i) begin
          state_nxt_s = IDLE;
          mul_clear_s = 1'b1;
        end else begin
          state_nxt_s  = IDLE;
          valid_nxt_s  = 1'b1;
          result_nxt_s = mul_res_s;
          rd_nxt_s     = rd_hold_r;
          pc_nxt_s     = pc_hold_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        mul_clear_s = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result bundle registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r  <= 1'b0;
      result_r <= '0;
      rd_r     <= '0;
      pc_r     <= '0;
    end else begin
      valid_r  <= valid_nxt_s;
      result_r <= result_nxt_s;
      rd_r     <= rd_nxt_s;
      pc_r     <= pc_nxt_s;
    end
  end

  // Side information of an accepted multiply, replayed at completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f3_hold_r <= '0;
      rd_hold_r <= '0;
      pc_hold_r <= '0;
    end else if (mul_start_s) begin
      f3_hold_r <= funct3_i;
      rd_hold_r <= rd_i;
      pc_hold_r <= next_pc_i;
    end
  end

  assign valid_o   = valid_r;
  assign result_o  = result_r;
  assign rd_o      = rd_r;
  assign next_pc_o = pc_r;

endmodule
